// File: rtl/prog_loader_if.sv
// Handshake and IROM write-port bundle between the word-stream source and the program loader.
// slave is the loader's view; master is the upstream feeder / observer.
interface prog_loader_if #(
  parameter int N_NODES = 12,
  parameter int PC_W    = 4,
  parameter int IW      = 32
);
  logic [IW-1:0]      in_data;
  logic               in_valid;
  logic               in_ready;
  logic [N_NODES-1:0] node_sel;
  logic [IW-1:0]      idata;
  logic [PC_W-1:0]    iaddr;
  logic               iwen;
  logic               halt;
  logic               done;
  logic               error;

  modport master (
    output in_data, in_valid,
    input  in_ready, node_sel, idata, iaddr, iwen, halt, done, error
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, node_sel, idata, iaddr, iwen, halt, done, error
  );
endinterface

// File: rtl/prog_loader.sv
// Streams header/instruction words into each node's IROM, padding unused slots with NOP_WORD
// and holding the global halt until an END header is seen.
module prog_loader #(
  parameter int N_NODES = 12,
  parameter int DEPTH   = 16,
  parameter int PC_W    = 4,
  parameter int IW      = 32,
  parameter logic [IW-1:0] NOP_WORD = '0
) (
  input logic          CLK,
  input logic          nRST,
  prog_loader_if.slave bus
);
  localparam int NODE_W = (N_NODES > 1) ? $clog2(N_NODES) : 1;
  localparam int CNT_W  = PC_W + 1;
  localparam logic [7:0]       END_NODE  = 8'hFF;
  localparam logic [7:0]       NODES_B   = 8'(N_NODES);
  localparam logic [7:0]       DEPTH_B   = 8'(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [PC_W-1:0]  LAST_ADDR = PC_W'(DEPTH - 1);

  typedef enum logic [2:0] {LOAD, DATA, PAD, RUN, ERR} state_t;

  state_t             state_q;
  logic [PC_W-1:0]    addr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NODE_W-1:0]  node_q;
  logic               in_ready_q;
  logic               halt_q;
  logic               done_q;
  logic               error_q;
  logic               iwen_q;
  logic [N_NODES-1:0] node_sel_q;
  logic [IW-1:0]      idata_q;
  logic [PC_W-1:0]    iaddr_q;

  logic               xfer;
  logic [7:0]         hdr_node;
  logic [7:0]         hdr_cnt;
  logic               hdr_end;
  logic               hdr_ok;
  logic [CNT_W-1:0]   addr_inc;
  logic [N_NODES-1:0] sel_onehot;

  assign xfer       = bus.in_valid & in_ready_q;
  assign hdr_node   = bus.in_data[7:0];
  assign hdr_cnt    = bus.in_data[15:8];
  assign hdr_end    = (hdr_node == END_NODE);
  assign hdr_ok     = (hdr_node < NODES_B) && (hdr_cnt <= DEPTH_B);
  assign addr_inc   = {1'b0, addr_q} + CNT_W'(1);
  assign sel_onehot = N_NODES'(1) << node_q;

  // Outputs are registered alongside the state so a word accepted in one cycle appears on the write port the next.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= LOAD;
      addr_q     <= '0;
      cnt_q      <= '0;
      node_q     <= '0;
      in_ready_q <= 1'b0;
      halt_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      iwen_q     <= 1'b0;
      node_sel_q <= '0;
      idata_q    <= '0;
      iaddr_q    <= '0;
    end else begin
      done_q     <= 1'b0;
      iwen_q     <= 1'b0;
      node_sel_q <= '0;
      unique case (state_q)
        LOAD, RUN: begin
          in_ready_q <= 1'b1;
          if (xfer) begin
            if (hdr_end) begin
              // A second END while already running must not re-pulse done.
              if (state_q == LOAD) begin
                state_q <= RUN;
                halt_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else if (hdr_ok) begin
              node_q <= NODE_W'(hdr_node);
              cnt_q  <= CNT_W'(hdr_cnt);
              addr_q <= '0;
              halt_q <= 1'b1;
              if (hdr_cnt == 8'd0) begin
                state_q    <= PAD;
                in_ready_q <= 1'b0;
              end else begin
                state_q <= DATA;
              end
            end else begin
              state_q    <= ERR;
              in_ready_q <= 1'b0;
              halt_q     <= 1'b1;
              error_q    <= 1'b1;
            end
          end
        end
        DATA: begin
          in_ready_q <= 1'b1;
          if (xfer) begin
            iwen_q     <= 1'b1;
            idata_q    <= bus.in_data;
            iaddr_q    <= addr_q;
            node_sel_q <= sel_onehot;
            addr_q     <= addr_q + PC_W'(1);
            if (addr_inc == cnt_q) begin
              if (cnt_q == FULL_CNT) begin
                state_q <= LOAD;
              end else begin
                state_q    <= PAD;
                in_ready_q <= 1'b0;
              end
            end
          end
        end
        PAD: begin
          iwen_q     <= 1'b1;
          idata_q    <= NOP_WORD;
          iaddr_q    <= addr_q;
          node_sel_q <= sel_onehot;
          addr_q     <= addr_q + PC_W'(1);
          if (addr_q == LAST_ADDR) begin
            state_q    <= LOAD;
            in_ready_q <= 1'b1;
          end else begin
            in_ready_q <= 1'b0;
          end
        end
        ERR: begin
          in_ready_q <= 1'b0;
          halt_q     <= 1'b1;
          error_q    <= 1'b1;
        end
        default: begin
          state_q    <= ERR;
          in_ready_q <= 1'b0;
          halt_q     <= 1'b1;
          error_q    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.halt     = halt_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;
  assign bus.iwen     = iwen_q;
  assign bus.node_sel = node_sel_q;
  assign bus.idata    = idata_q;
  assign bus.iaddr    = iaddr_q;
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed test-plan loads plus randomized header/word streams,
// compared every cycle against a transaction-level model of the loader's rules.
module tb_prog_loader;
  localparam int N_NODES = 12;
  localparam int DEPTH   = 16;
  localparam int PC_W    = 4;
  localparam int IW      = 32;
  localparam logic [IW-1:0] NOP = '0;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  prog_loader_if #(.N_NODES(N_NODES), .PC_W(PC_W), .IW(IW)) bus ();

  prog_loader #(.N_NODES(N_NODES), .DEPTH(DEPTH), .PC_W(PC_W), .IW(IW), .NOP_WORD(NOP)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a load is "data words left" then "pad slots left"; ready drops only while padding or in error.
  logic               expReady, expHalt, expDone, expErr, expWen;
  logic [N_NODES-1:0] expSel;
  logic [IW-1:0]      expData;
  logic [PC_W-1:0]    expAddr;
  int  dataLeft, padLeft, wordIdx, curNode, curCnt, hNode, hCnt;
  bit  running, errored, modelLive = 0, mAcc;

  always @(posedge clk) begin
    if (!nrst) begin
      expReady = 0; expHalt = 1; expDone = 0; expErr = 0; expWen = 0;
      expSel = '0; expData = '0; expAddr = '0;
      dataLeft = 0; padLeft = 0; wordIdx = 0; curNode = 0; curCnt = 0;
      running = 0; errored = 0; modelLive = 1;
    end else begin
      mAcc = (bus.in_valid === 1'b1) && expReady;
      expDone = 0; expWen = 0; expSel = '0;
      if (errored) begin
      end else if (padLeft > 0) begin
        expWen = 1; expSel[curNode] = 1'b1; expData = NOP; expAddr = PC_W'(DEPTH - padLeft);
        padLeft--;
      end else if (dataLeft > 0) begin
        if (mAcc) begin
          expWen = 1; expSel[curNode] = 1'b1; expData = bus.in_data; expAddr = PC_W'(wordIdx);
          wordIdx++; dataLeft--;
          if (dataLeft == 0) padLeft = DEPTH - curCnt;
        end
      end else if (mAcc) begin
        hNode = int'(bus.in_data[7:0]);
        hCnt  = int'(bus.in_data[15:8]);
        if (hNode == 255) begin
          if (!running) begin running = 1; expDone = 1; end
        end else if (hNode < N_NODES && hCnt <= DEPTH) begin
          running = 0; curNode = hNode; curCnt = hCnt; wordIdx = 0;
          dataLeft = hCnt; padLeft = (hCnt == 0) ? DEPTH : 0;
        end else begin
          errored = 1; running = 0;
        end
      end
      expHalt  = !running;
      expErr   = errored;
      expReady = !errored && (padLeft == 0);
    end
  end

  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("in_ready", bus.in_ready, expReady);
      checkOutput("halt",     bus.halt,     expHalt);
      checkOutput("done",     bus.done,     expDone);
      checkOutput("error",    bus.error,    expErr);
      checkOutput("iwen",     bus.iwen,     expWen);
      checkOutput("node_sel", bus.node_sel, expSel);
      checkOutput("idata",    bus.idata,    expData);
      checkOutput("iaddr",    bus.iaddr,    expAddr);
    end
  end

  // Observed write-port activity, used by the literal test-plan checks.
  logic [IW-1:0]      romSeen [N_NODES][DEPTH];
  logic [N_NODES-1:0] lastSel = '0;
  int wenCount = 0, notReadyCount = 0, doneCount = 0;

  always @(negedge clk) begin
    if (bus.iwen === 1'b1) begin
      wenCount++;
      lastSel = bus.node_sel;
      for (int i = 0; i < N_NODES; i++)
        if (bus.node_sel[i] === 1'b1) romSeen[i][bus.iaddr] = bus.idata;
    end
    if (bus.in_ready === 1'b0 && bus.error === 1'b0) notReadyCount++;
    if (bus.done === 1'b1) doneCount++;
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clearCounters();
    wenCount = 0; notReadyCount = 0; doneCount = 0;
  endtask

  task automatic applyStimulus(input logic [IW-1:0] w, input int gap);
    bit acc;
    int guard;
    acc = 0; guard = 0;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = (bus.in_ready === 1'b1);
      @(posedge clk); #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("[TB] FAIL handshake_timeout actual=no_accept required=accept word=0x%0h", w);
    end
    idle(gap);
  endtask

  task automatic pulseReset();
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
  endtask

  logic [IW-1:0] words [DEPTH];
  logic [15:0]   upper;
  logic [IW-1:0] xWord;
  int            rnode, rcnt;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    nrst = 1'b0;
    idle(2);
    nrst = 1'b1;
    idle(3);

    @(negedge clk);
    checkOutput("rst_halt",     bus.halt,     1);
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_iwen",     bus.iwen,     0);
    checkOutput("rst_node_sel", bus.node_sel, 0);
    checkOutput("rst_error",    bus.error,    0);
    @(posedge clk); #1;

    // Node 2, three words, then 13 pad slots.
    clearCounters();
    applyStimulus(32'h0003_0302, 0);
    applyStimulus(32'hA5A5_0001, 0);
    applyStimulus(32'hB6B6_0002, 0);
    applyStimulus(32'hC7C7_0003, 0);
    idle(20);
    checkOutput("n2_wen_count",  wenCount,      16);
    checkOutput("n2_pad_cycles", notReadyCount, 13);
    checkOutput("n2_node_sel",   lastSel,       12'b000000000100);
    checkOutput("n2_slot0",      romSeen[2][0], 32'hA5A5_0001);
    checkOutput("n2_slot1",      romSeen[2][1], 32'hB6B6_0002);
    checkOutput("n2_slot2",      romSeen[2][2], 32'hC7C7_0003);
    checkOutput("n2_slot3",      romSeen[2][3], NOP);
    checkOutput("n2_slot15",     romSeen[2][15], NOP);

    // Node 5, full 16 words with a bubble after each.
    clearCounters();
    applyStimulus(32'h0000_1005, 1);
    for (int i = 0; i < DEPTH; i++) begin
      words[i] = 32'($urandom);
      applyStimulus(words[i], 1);
    end
    idle(5);
    checkOutput("n5_wen_count",  wenCount,       16);
    checkOutput("n5_pad_cycles", notReadyCount,  0);
    checkOutput("n5_slot0",      romSeen[5][0],  words[0]);
    checkOutput("n5_slot15",     romSeen[5][15], words[15]);

    // Node 0, empty program, then END.
    clearCounters();
    applyStimulus(32'h0000_0000, 0);
    idle(20);
    checkOutput("n0_wen_count", wenCount,       16);
    checkOutput("n0_slot15",    romSeen[0][15], NOP);
    clearCounters();
    applyStimulus(32'h0000_00FF, 0);
    idle(3);
    @(negedge clk);
    checkOutput("end_done_count", doneCount, 1);
    checkOutput("end_halt",       bus.halt,  0);
    @(posedge clk); #1;

    // Reload from RUN: halt rises right after the header.
    clearCounters();
    applyStimulus(32'h0000_0101, 0);
    @(negedge clk);
    checkOutput("run_reload_halt", bus.halt, 1);
    @(posedge clk); #1;
    xWord = 32'hDEAD_BEEF;
    applyStimulus(xWord, 0);
    idle(20);
    checkOutput("n1_wen_count", wenCount,      16);
    checkOutput("n1_slot0",     romSeen[1][0], xWord);
    checkOutput("n1_slot1",     romSeen[1][1], NOP);
    checkOutput("n1_halt_held", bus.halt,      1);

    // END twice: the second one arrives in RUN and must be ignored.
    clearCounters();
    applyStimulus(32'h1234_00FF, 0);
    applyStimulus(32'h0000_00FF, 0);
    idle(3);
    checkOutput("end_twice_done_count", doneCount, 1);

    // Randomized loads and END headers, checked cycle by cycle by the model.
    for (int it = 0; it < 14; it++) begin
      upper = 16'($urandom);
      if ($urandom_range(0, 9) < 2) begin
        applyStimulus({upper, 8'($urandom), 8'hFF}, $urandom_range(0, 2));
      end else begin
        rnode = $urandom_range(0, N_NODES - 1);
        rcnt  = $urandom_range(0, DEPTH);
        applyStimulus({upper, 8'(rcnt), 8'(rnode)}, $urandom_range(0, 2));
        for (int i = 0; i < rcnt; i++) applyStimulus(32'($urandom), $urandom_range(0, 2));
      end
    end
    idle(20);

    // Bad node index: sticky error until reset.
    applyStimulus(32'h0000_010C, 0);
    idle(4);
    @(negedge clk);
    checkOutput("err_node_error", bus.error,    1);
    checkOutput("err_node_ready", bus.in_ready, 0);
    checkOutput("err_node_halt",  bus.halt,     1);
    @(posedge clk); #1;
    pulseReset();
    @(negedge clk);
    checkOutput("err_rst_error", bus.error, 0);
    checkOutput("err_rst_halt",  bus.halt,  1);
    @(posedge clk); #1;
    idle(2);

    // Oversized count.
    applyStimulus(32'h0000_1103, 0);
    idle(3);
    @(negedge clk);
    checkOutput("err_cnt_error", bus.error,    1);
    checkOutput("err_cnt_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    pulseReset();
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
